// File: rtl/lfsr_cfg_arbiter.sv
// Round-robin arbiter sharing one LFSR_CFG.
// Sequences poly, seed, cnt steps, capture.
`timescale 1ns/1ps
module lfsr_cfg_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int N       = 32,
  parameter int CNT_W   = 32
) (
  input  logic                     up_clk,
  input  logic                     up_rstn,
  input  logic [NUM_REQ-1:0]       req_valid,
  input  logic [NUM_REQ*N-1:0]     req_poly,
  input  logic [NUM_REQ*N-1:0]     req_seed,
  input  logic [NUM_REQ*CNT_W-1:0] req_cnt,
  output logic [NUM_REQ-1:0]       req_ready,
  output logic                     resp_valid,
  output logic [2:0]               resp_id,
  output logic [N-1:0]             resp_q,
  output logic                     busy,
  output logic                     lfsr_enable,
  output logic                     lfsr_seed,
  output logic                     lfsr_poly,
  output logic [N-1:0]             lfsr_din,
  input  logic [N-1:0]             lfsr_q
);

  typedef enum logic [5:0] {
    S_IDLE = 6'b000001,
    S_POLY = 6'b000010,
    S_SEED = 6'b000100,
    S_RUN  = 6'b001000,
    S_CAPT = 6'b010000,
    S_DONE = 6'b100000
  } state_t;

  localparam logic [CNT_W-1:0] ONE = 1;
  localparam logic [NUM_REQ-1:0] BIT0 = 1;

  state_t             r_state;
  state_t             w_nstate;
  logic [2:0]         r_rr_ptr;
  logic [N-1:0]       r_jpoly;
  logic [N-1:0]       r_jseed;
  logic [CNT_W-1:0]   r_jcnt;
  logic [2:0]         r_jid;
  logic [CNT_W-1:0]   r_step;

  logic [NUM_REQ-1:0] r_ready;
  logic               r_rv;
  logic [2:0]         r_rid;
  logic [N-1:0]       r_rq;
  logic               r_busy;
  logic               r_en;
  logic               r_sd;
  logic               r_pl;
  logic [N-1:0]       r_din;

  logic [7:0]         w_req_ext;
  logic [3:0]         w_sum;
  logic               w_found;
  logic [2:0]         w_idx;

  logic [NUM_REQ-1:0] w_ready;
  logic               w_accept;
  logic               w_rv;
  logic               w_busy;
  logic               w_en;
  logic               w_sd;
  logic               w_pl;
  logic [N-1:0]       w_din;
  logic               w_clr;
  logic               w_inc;

  // Round-robin scan starting at the pointer.
  always_comb begin
    w_req_ext = 8'(req_valid);
    w_sum     = '0;
    w_found   = 1'b0;
    w_idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + 4'(k);
      if (w_sum >= 4'(NUM_REQ))
        w_sum = w_sum - 4'(NUM_REQ);
      if (!w_found && w_req_ext[w_sum[2:0]]) begin
        w_found = 1'b1;
        w_idx   = w_sum[2:0];
      end
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    w_nstate = r_state;
    w_ready  = '0;
    w_accept = 1'b0;
    w_rv     = 1'b0;
    w_busy   = (r_state != S_IDLE);
    w_en     = 1'b0;
    w_sd     = 1'b0;
    w_pl     = 1'b0;
    w_din    = '0;
    w_clr    = 1'b0;
    w_inc    = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_accept = 1'b1;
          w_ready  = BIT0 << w_idx;
          w_nstate = S_POLY;
        end
      end
      S_POLY: begin
        w_pl     = 1'b1;
        w_din    = r_jpoly;
        w_nstate = S_SEED;
      end
      S_SEED: begin
        w_sd     = 1'b1;
        w_din    = r_jseed;
        w_clr    = 1'b1;
        w_nstate = (r_jcnt != '0) ? S_RUN : S_CAPT;
      end
      S_RUN: begin
        w_en  = 1'b1;
        w_inc = 1'b1;
        if (r_step == r_jcnt - ONE)
          w_nstate = S_CAPT;
      end
      S_CAPT: w_nstate = S_DONE;
      S_DONE: begin
        w_rv     = 1'b1;
        w_nstate = S_IDLE;
      end
      default: w_nstate = S_IDLE;
    endcase
  end

  // State, pointer and job registers.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      r_state  <= S_IDLE;
      r_rr_ptr <= '0;
      r_jpoly  <= '0;
      r_jseed  <= '0;
      r_jcnt   <= '0;
      r_jid    <= '0;
      r_step   <= '0;
    end else begin
      r_state <= w_nstate;
      if (w_accept) begin
        r_jpoly  <= req_poly[w_idx*N +: N];
        r_jseed  <= req_seed[w_idx*N +: N];
        r_jcnt   <= req_cnt[w_idx*CNT_W +: CNT_W];
        r_jid    <= w_idx;
        r_rr_ptr <= (w_idx == 3'(NUM_REQ-1))
                    ? 3'd0 : w_idx + 3'd1;
      end
      if (w_clr)
        r_step <= '0;
      else if (w_inc)
        r_step <= r_step + ONE;
    end
  end

  // Registered outputs.
  always_ff @(posedge up_clk) begin
    if (!up_rstn) begin
      r_ready <= '0;
      r_rv    <= 1'b0;
      r_rid   <= '0;
      r_rq    <= '0;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_sd    <= 1'b0;
      r_pl    <= 1'b0;
      r_din   <= '0;
    end else begin
      r_ready <= w_ready;
      r_rv    <= w_rv;
      r_busy  <= w_busy;
      r_en    <= w_en;
      r_sd    <= w_sd;
      r_pl    <= w_pl;
      r_din   <= w_din;
      if (w_rv) begin
        r_rid <= r_jid;
        r_rq  <= lfsr_q;
      end
    end
  end

  assign req_ready   = r_ready;
  assign resp_valid  = r_rv;
  assign resp_id     = r_rid;
  assign resp_q      = r_rq;
  assign busy        = r_busy;
  assign lfsr_enable = r_en;
  assign lfsr_seed   = r_sd;
  assign lfsr_poly   = r_pl;
  assign lfsr_din    = r_din;

endmodule

// File: tb/tb_lfsr_cfg_arbiter.sv
// Directed bench for lfsr_cfg_arbiter.
// Includes a behavioural LFSR_CFG.
`timescale 1ns/1ps
module tb_lfsr_cfg_arbiter;

  localparam int NR = 4;
  localparam int N  = 32;
  localparam int CW = 32;

  logic           up_clk = 1'b0;
  logic           up_rstn = 1'b0;
  logic [NR-1:0]  req_valid = '0;
  logic [NR*N-1:0] req_poly = '0;
  logic [NR*N-1:0] req_seed = '0;
  logic [NR*CW-1:0] req_cnt = '0;
  logic [NR-1:0]  req_ready;
  logic           resp_valid;
  logic [2:0]     resp_id;
  logic [N-1:0]   resp_q;
  logic           busy;
  logic           lfsr_enable;
  logic           lfsr_seed;
  logic           lfsr_poly;
  logic [N-1:0]   lfsr_din;
  logic [N-1:0]   lfsr_q = '0;
  logic [N-1:0]   m_poly = '0;

  int checks = 0;
  int failures = 0;

  always #5 up_clk = ~up_clk;

  lfsr_cfg_arbiter #(.NUM_REQ(NR), .N(N), .CNT_W(CW)) dut (
    .up_clk(up_clk), .up_rstn(up_rstn),
    .req_valid(req_valid), .req_poly(req_poly),
    .req_seed(req_seed), .req_cnt(req_cnt),
    .req_ready(req_ready), .resp_valid(resp_valid),
    .resp_id(resp_id), .resp_q(resp_q), .busy(busy),
    .lfsr_enable(lfsr_enable), .lfsr_seed(lfsr_seed),
    .lfsr_poly(lfsr_poly), .lfsr_din(lfsr_din),
    .lfsr_q(lfsr_q)
  );

  function automatic logic [N-1:0] step(
    input logic [N-1:0] q, input logic [N-1:0] p);
    return {q[N-2:0], ^(q & p)};
  endfunction

  function automatic logic [N-1:0] lfsr_ref(
    input logic [N-1:0] p, input logic [N-1:0] s,
    input int c);
    logic [N-1:0] q;
    q = s;
    for (int i = 0; i < c; i++) q = step(q, p);
    return q;
  endfunction

  // Behavioural LFSR_CFG: Fibonacci, shift-left.
  always @(posedge up_clk) begin
    if (lfsr_poly) m_poly <= lfsr_din;
    if (lfsr_seed) lfsr_q <= lfsr_din;
    else if (lfsr_enable) lfsr_q <= step(lfsr_q, m_poly);
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge up_clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [N-1:0] p,
                         input logic [N-1:0] s, input int c);
    req_poly[i*N +: N] = p;
    req_seed[i*N +: N] = s;
    req_cnt[i*CW +: CW] = CW'(c);
  endtask

  task automatic do_reset();
    up_rstn = 1'b0;
    tick();
    tick();
    up_rstn = 1'b1;
  endtask

  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 50 && g < 0; i++) begin
      tick();
      for (int j = 0; j < NR; j++)
        if (req_ready[j]) g = j;
    end
  endtask

  task automatic observe(
    input int ncyc,
    output int pl_k, output int sd_k, output int en_n,
    output int en_first, output int en_last,
    output int rv_n, output int rv_k, output int busy_low,
    output int viol,
    output logic [N-1:0] pl_din, output logic [N-1:0] sd_din,
    output logic [N-1:0] rq, output logic [2:0] rid);
    pl_k = -1; sd_k = -1; en_n = 0; en_first = -1;
    en_last = -1; rv_n = 0; rv_k = -1; busy_low = 0;
    viol = 0; pl_din = '0; sd_din = '0; rq = '0; rid = '0;
    for (int k = 1; k <= ncyc; k++) begin
      tick();
      if (int'(lfsr_poly) + int'(lfsr_seed)
          + int'(lfsr_enable) > 1) viol++;
      if (!lfsr_poly && !lfsr_seed && lfsr_din != '0)
        viol++;
      if (!busy && rv_n == 0) busy_low++;
      if (lfsr_poly) begin pl_k = k; pl_din = lfsr_din; end
      if (lfsr_seed) begin sd_k = k; sd_din = lfsr_din; end
      if (lfsr_enable) begin
        en_n++;
        if (en_first < 0) en_first = k;
        en_last = k;
      end
      if (resp_valid) begin
        rv_n++; rv_k = k; rq = resp_q; rid = resp_id;
      end
    end
  endtask

  int pl_k, sd_k, en_n, en_f, en_l, rv_n, rv_k, bl, vi;
  logic [N-1:0] pd, sdn, rq;
  logic [2:0] rid;

  task automatic test_reset();
    up_rstn = 1'b0;
    req_valid = '0;
    tick();
    tick();
    checks++;
    if (req_ready !== '0 || resp_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got=%b/%b exp=0", req_ready,
               resp_valid);
    end
    checks++;
    if (resp_id !== 3'd0 || resp_q !== '0) begin
      failures++;
      $display("FAIL reset_resp got=%0d/%h exp=0", resp_id,
               resp_q);
    end
    checks++;
    if ({busy, lfsr_enable, lfsr_seed, lfsr_poly} !== 4'b0) begin
      failures++;
      $display("FAIL reset_strb got=%b exp=0",
               {busy, lfsr_enable, lfsr_seed, lfsr_poly});
    end
    checks++;
    if (lfsr_din !== '0) begin
      failures++;
      $display("FAIL reset_din got=%h exp=0", lfsr_din);
    end
    up_rstn = 1'b1;
  endtask

  task automatic test_single();
    int g;
    set_req(0, 32'h80200003, 32'h00000001, 5);
    req_valid = 4'b0001;
    wait_grant(g);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL single_ready got=%b exp=0001", req_ready);
    end
    req_valid = '0;
    observe(12, pl_k, sd_k, en_n, en_f, en_l, rv_n, rv_k,
            bl, vi, pd, sdn, rq, rid);
    checks++;
    if (pl_k !== 1 || pd !== 32'h80200003) begin
      failures++;
      $display("FAIL single_poly got=%0d/%h exp=1/80200003",
               pl_k, pd);
    end
    checks++;
    if (sd_k !== 2 || sdn !== 32'h00000001) begin
      failures++;
      $display("FAIL single_seed got=%0d/%h exp=2/00000001",
               sd_k, sdn);
    end
    checks++;
    if (en_n !== 5 || en_f !== 3 || en_l !== 7) begin
      failures++;
      $display("FAIL single_en got=%0d@%0d..%0d exp=5@3..7",
               en_n, en_f, en_l);
    end
    checks++;
    if (rv_n !== 1 || rv_k !== 9) begin
      failures++;
      $display("FAIL single_rv got=%0d@%0d exp=1@9", rv_n, rv_k);
    end
    checks++;
    if (rid !== 3'd0 || rq !== 32'h00000036) begin
      failures++;
      $display("FAIL single_q got=%0d/%h exp=0/00000036",
               rid, rq);
    end
    checks++;
    if (bl !== 0) begin
      failures++;
      $display("FAIL single_busy got=%0d exp=0", bl);
    end
  endtask

  task automatic test_cnt0();
    int g;
    set_req(1, 32'h80200003, 32'hDEADBEEF, 0);
    req_valid = 4'b0010;
    wait_grant(g);
    req_valid = '0;
    checks++;
    if (g !== 1) begin
      failures++;
      $display("FAIL cnt0_grant got=%0d exp=1", g);
    end
    observe(8, pl_k, sd_k, en_n, en_f, en_l, rv_n, rv_k,
            bl, vi, pd, sdn, rq, rid);
    checks++;
    if (en_n !== 0) begin
      failures++;
      $display("FAIL cnt0_en got=%0d exp=0", en_n);
    end
    checks++;
    if (rv_n !== 1 || rv_k !== 4) begin
      failures++;
      $display("FAIL cnt0_rv got=%0d@%0d exp=1@4", rv_n, rv_k);
    end
    checks++;
    if (rq !== 32'hDEADBEEF || rid !== 3'd1) begin
      failures++;
      $display("FAIL cnt0_q got=%0d/%h exp=1/deadbeef", rid, rq);
    end
  endtask

  task automatic test_round_robin();
    int g;
    int exp_g;
    do_reset();
    for (int i = 0; i < NR; i++)
      set_req(i, 32'h80200003, N'((i + 1) * 32'h11111111), 3);
    req_valid = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      exp_g = n % NR;
      wait_grant(g);
      if (n == 4) req_valid = '0;
      checks++;
      if (g !== exp_g) begin
        failures++;
        $display("FAIL rr_grant%0d got=%0d exp=%0d", n, g, exp_g);
      end
      if (g < 0) break;
      observe(7, pl_k, sd_k, en_n, en_f, en_l, rv_n, rv_k,
              bl, vi, pd, sdn, rq, rid);
      checks++;
      if (rv_k !== 7 || int'(rid) !== g) begin
        failures++;
        $display("FAIL rr_resp%0d got=%0d@%0d exp=%0d@7",
                 n, rid, rv_k, g);
      end
      checks++;
      if (rq !== lfsr_ref(32'h80200003,
                          N'((g + 1) * 32'h11111111), 3)) begin
        failures++;
        $display("FAIL rr_q%0d got=%h", n, rq);
      end
      checks++;
      if (bl !== 0) begin
        failures++;
        $display("FAIL rr_busy%0d got=%0d exp=0", n, bl);
      end
    end
  endtask

  task automatic test_fairness();
    int g;
    do_reset();
    set_req(1, 32'h0000000F, 32'h00000005, 1);
    req_valid = 4'b0010;
    wait_grant(g);
    req_valid = '0;
    observe(6, pl_k, sd_k, en_n, en_f, en_l, rv_n, rv_k,
            bl, vi, pd, sdn, rq, rid);
    set_req(0, 32'h0000000F, 32'h00000007, 1);
    set_req(3, 32'h0000000F, 32'h00000009, 1);
    req_valid = 4'b1001;
    wait_grant(g);
    checks++;
    if (g !== 3) begin
      failures++;
      $display("FAIL fair_first got=%0d exp=3", g);
    end
    observe(5, pl_k, sd_k, en_n, en_f, en_l, rv_n, rv_k,
            bl, vi, pd, sdn, rq, rid);
    checks++;
    if (rid !== 3'd3 || rv_k !== 5) begin
      failures++;
      $display("FAIL fair_id3 got=%0d@%0d exp=3@5", rid, rv_k);
    end
    wait_grant(g);
    req_valid = '0;
    checks++;
    if (g !== 0) begin
      failures++;
      $display("FAIL fair_second got=%0d exp=0", g);
    end
    observe(6, pl_k, sd_k, en_n, en_f, en_l, rv_n, rv_k,
            bl, vi, pd, sdn, rq, rid);
    checks++;
    if (rid !== 3'd0 || rv_n !== 1) begin
      failures++;
      $display("FAIL fair_id0 got=%0d/%0d exp=0/1", rid, rv_n);
    end
  endtask

  task automatic test_reset_mid_run();
    int g;
    do_reset();
    set_req(2, 32'h80200003, 32'h00000001, 100);
    req_valid = 4'b0100;
    wait_grant(g);
    req_valid = '0;
    checks++;
    if (g !== 2) begin
      failures++;
      $display("FAIL mid_grant got=%0d exp=2", g);
    end
    tick(); tick(); tick(); tick();
    checks++;
    if (lfsr_enable !== 1'b1) begin
      failures++;
      $display("FAIL mid_run got=%b exp=1", lfsr_enable);
    end
    up_rstn = 1'b0;
    tick();
    checks++;
    if ({lfsr_enable, lfsr_seed, lfsr_poly, busy,
         resp_valid} !== 5'b0 || lfsr_din !== '0
        || req_ready !== '0) begin
      failures++;
      $display("FAIL mid_zero got=%b/%h exp=0",
               {lfsr_enable, lfsr_seed, lfsr_poly, busy,
                resp_valid}, lfsr_din);
    end
    tick();
    up_rstn = 1'b1;
    set_req(1, 32'h80200003, 32'h00000003, 2);
    set_req(3, 32'h80200003, 32'h00000004, 2);
    req_valid = 4'b1010;
    wait_grant(g);
    req_valid = '0;
    checks++;
    if (g !== 1) begin
      failures++;
      $display("FAIL mid_after got=%0d exp=1", g);
    end
    observe(8, pl_k, sd_k, en_n, en_f, en_l, rv_n, rv_k,
            bl, vi, pd, sdn, rq, rid);
    checks++;
    if (rv_n !== 1 || rv_k !== 6 || rid !== 3'd1) begin
      failures++;
      $display("FAIL mid_resp got=%0d@%0d id%0d exp=1@6 id1",
               rv_n, rv_k, rid);
    end
  endtask

  task automatic test_random();
    int g;
    int ptr;
    int exp_g;
    int c;
    logic [NR-1:0] mask;
    do_reset();
    ptr = 0;
    for (int j = 0; j < 200; j++) begin
      mask = NR'($urandom_range(1, 15));
      for (int i = 0; i < NR; i++)
        set_req(i, $urandom, $urandom,
                int'($urandom_range(0, 20)));
      exp_g = -1;
      for (int k = 0; k < NR && exp_g < 0; k++)
        if (mask[(ptr + k) % NR]) exp_g = (ptr + k) % NR;
      req_valid = mask;
      wait_grant(g);
      req_valid = '0;
      checks++;
      if (g !== exp_g) begin
        failures++;
        $display("FAIL rnd_grant%0d got=%0d exp=%0d", j, g,
                 exp_g);
      end
      if (g < 0) break;
      ptr = (g + 1) % NR;
      c = int'(req_cnt[g*CW +: CW]);
      observe(c + 7, pl_k, sd_k, en_n, en_f, en_l, rv_n, rv_k,
              bl, vi, pd, sdn, rq, rid);
      checks++;
      if (vi !== 0) begin
        failures++;
        $display("FAIL rnd_strobe%0d got=%0d exp=0", j, vi);
      end
      checks++;
      if (rv_n !== 1 || rv_k !== c + 4 || en_n !== c) begin
        failures++;
        $display("FAIL rnd_rv%0d got=%0d@%0d en%0d exp=1@%0d",
                 j, rv_n, rv_k, en_n, c + 4);
      end
      checks++;
      if (int'(rid) !== g
          || rq !== lfsr_ref(req_poly[g*N +: N],
                             req_seed[g*N +: N], c)) begin
        failures++;
        $display("FAIL rnd_q%0d got=%0d/%h", j, rid, rq);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_cnt0();
    test_round_robin();
    test_fairness();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks,
             failures);
    $finish;
  end

endmodule
